axonerve_kvs_job_sequencer: RTL and testbench
=============================================

Name: axonerve_kvs_job_sequencer

Overview:
- Top-level job controller in front of the KVS read-master / user-logic / write-master datapath.
- Accepts one host job (base address, total bytes) and splits it into chunks of at most C_CHUNK_BYTES.
- For each chunk: issues one datapath start, waits for datapath done, advances address, then pulses ap_done once the whole job completes.
- Lets large host buffers stream through a datapath whose burst/outstanding resources are sized per chunk.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, width of address offsets.
- C_XFER_SIZE_WIDTH, 32, width of byte counts.
- C_CHUNK_BYTES, 65536, max bytes per datapath run; power of two, multiple of 64.
- C_CNT_WIDTH, 16, width of chunk counter.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- ap_start  in  1  job request; level, sampled only in IDLE.
- ap_done  out  1  one-cycle pulse when the job completes.
- ap_idle  out  1  high while in IDLE.
- ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  job base byte address.
- ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  job total bytes, multiple of 64.
- dp_start  out  1  one-cycle start pulse to the datapath.
- dp_addr_offset  out  C_M_AXI_ADDR_WIDTH  current chunk address; stable from dp_start until dp_done.
- dp_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  current chunk bytes; stable from dp_start until dp_done.
- dp_done  in  1  datapath completion pulse (write-master done).
- chunk_count  out  C_CNT_WIDTH  chunks completed in the current or last job.

Behaviour:
- Reset state: FSM=IDLE; ap_done=0, ap_idle=1, dp_start=0, dp_addr_offset=0, dp_xfer_size_in_bytes=0, chunk_count=0; internal remaining=0.
- All outputs are driven from flops. No combinational path from any input to any output.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, ap_start=1 at edge T:
  - Latch base into dp_addr_offset and size into remaining; clear chunk_count.
  - If size==0, go to DONE (ap_done high in cycle T+1, no dp_start issued).
  - Otherwise set dp_xfer_size_in_bytes = min(size, C_CHUNK_BYTES) and go to ISSUE (dp_start high in cycle T+1).
- ISSUE:
  - dp_start=1 for exactly this one cycle; go to WAIT unconditionally.
  - A dp_done seen in ISSUE is ignored; datapath done must come after start.
- WAIT, dp_done=1 at edge N:
  - Increment chunk_count, saturating at all-ones.
  - Compute rem_next = remaining - dp_xfer_size_in_bytes.
  - If rem_next==0, go to DONE (ap_done high in cycle N+1).
  - Otherwise: dp_addr_offset += dp_xfer_size_in_bytes (wraps modulo 2^C_M_AXI_ADDR_WIDTH); remaining = rem_next; dp_xfer_size_in_bytes = min(rem_next, C_CHUNK_BYTES); go to ISSUE (next dp_start in cycle N+1).
- DONE: ap_done=1 for one cycle; go to IDLE. ap_idle rises in the cycle after ap_done.
- ap_start held high across DONE starts a new job only once back in IDLE. Minimum gap between ap_done and the next dp_start is 2 cycles.
- ap_start and ctrl_* changes while not in IDLE are ignored; latched values are used.
- dp_done in IDLE or DONE is ignored. chunk_count holds its last value until the next accepted ap_start.
- min() compares at C_XFER_SIZE_WIDTH bits. C_CHUNK_BYTES must fit in C_XFER_SIZE_WIDTH.
- areset mid-job: immediate return to reset state; no ap_done is produced for the aborted job.

Optional Feature:
- Macro: AXONERVE_KVS_SEQ_PERF_CNT_EN.
- When defined, add output perf_cycles (32 bits):
  - Cleared on an accepted ap_start.
  - Increments every cycle in ISSUE or WAIT, saturating at 0xFFFFFFFF.
  - Holds its value in DONE and IDLE; reset value 0.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Single chunk: base 0x1000, size 4096, dp_done 10 cycles after dp_start.
  -> one dp_start with addr 0x1000, size 4096; ap_done exactly 1 cycle after dp_done; chunk_count=1.
- Multi-chunk, C_CHUNK_BYTES=65536: size 150000-rounded-to-64 = 150016, base 0x0.
  -> three dp_start pulses: (0x0, 65536), (0x10000, 65536), (0x20000, 18944); ap_done after the third dp_done; chunk_count=3.
- Zero size: ap_start with size 0.
  -> no dp_start; ap_done one cycle after ap_start is sampled; ap_idle high again the following cycle.
- Busy ignore: ap_start toggled and ctrl_addr_offset changed to 0xDEAD00 during WAIT.
  -> dp_addr_offset unchanged; only the original job's chunks are issued.
- Reset mid-job: assert areset during WAIT of chunk 2.
  -> all outputs go to reset values immediately, no ap_done; a following job of 64 bytes at base 0x40 runs cleanly.
- Perf counter (macro defined): single chunk with dp_done 20 cycles after dp_start.
  -> perf_cycles = 21 (1 ISSUE + 20 WAIT, counting the dp_done cycle), held after ap_done.

Source files
------------

// File: rtl/axonerve_kvs_job_sequencer_if.sv
// Host/datapath handshake bundle for the KVS job sequencer.
// Optional perf_cycles signal present under AXONERVE_KVS_SEQ_PERF_CNT_EN.
interface axonerve_kvs_job_sequencer_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_CNT_WIDTH        = 16
);
  logic                          ap_start;
  logic                          ap_done;
  logic                          ap_idle;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes;
  logic                          dp_start;
  logic [C_M_AXI_ADDR_WIDTH-1:0] dp_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  dp_xfer_size_in_bytes;
  logic                          dp_done;
  logic [C_CNT_WIDTH-1:0]        chunk_count;
`ifdef AXONERVE_KVS_SEQ_PERF_CNT_EN
  logic [31:0]                   perf_cycles;
`endif

  modport master (
    output ap_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, dp_done,
    input  ap_done, ap_idle, dp_start, dp_addr_offset, dp_xfer_size_in_bytes,
`ifdef AXONERVE_KVS_SEQ_PERF_CNT_EN
    input  perf_cycles,
`endif
    input  chunk_count
  );

  modport slave (
    input  ap_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes, dp_done,
    output ap_done, ap_idle, dp_start, dp_addr_offset, dp_xfer_size_in_bytes,
`ifdef AXONERVE_KVS_SEQ_PERF_CNT_EN
    output perf_cycles,
`endif
    output chunk_count
  );
endinterface

// File: rtl/axonerve_kvs_job_sequencer.sv
// Splits one host job into <= C_CHUNK_BYTES datapath runs and sequences start/done.
// Define AXONERVE_KVS_SEQ_PERF_CNT_EN to add the perf_cycles busy-cycle counter.
module axonerve_kvs_job_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_CHUNK_BYTES      = 65536,
  parameter int C_CNT_WIDTH        = 16
) (
  input  logic                             aclk,
  input  logic                             areset,
  axonerve_kvs_job_sequencer_if.slave      bus
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int XW = C_XFER_SIZE_WIDTH;
  localparam logic [XW-1:0] CHUNK = XW'(C_CHUNK_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [XW-1:0]   remaining;
  logic [XW-1:0]   rem_next;

  function automatic logic [XW-1:0] clip(input logic [XW-1:0] v);
    return (v < CHUNK) ? v : CHUNK;
  endfunction

  assign rem_next = remaining - bus.dp_xfer_size_in_bytes;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state                     <= S_IDLE;
      remaining                 <= '0;
      bus.ap_done               <= 1'b0;
      bus.ap_idle               <= 1'b1;
      bus.dp_start              <= 1'b0;
      bus.dp_addr_offset        <= '0;
      bus.dp_xfer_size_in_bytes <= '0;
      bus.chunk_count           <= '0;
`ifdef AXONERVE_KVS_SEQ_PERF_CNT_EN
      bus.perf_cycles           <= '0;
`endif
    end else begin
      bus.ap_done  <= 1'b0;
      bus.dp_start <= 1'b0;
`ifdef AXONERVE_KVS_SEQ_PERF_CNT_EN
      if ((state == S_ISSUE || state == S_WAIT) && !(&bus.perf_cycles))
        bus.perf_cycles <= bus.perf_cycles + 32'd1;
`endif
      case (state)
        S_IDLE: if (bus.ap_start) begin
          bus.dp_addr_offset <= bus.ctrl_addr_offset;
          remaining          <= bus.ctrl_xfer_size_in_bytes;
          bus.chunk_count    <= '0;
          bus.ap_idle        <= 1'b0;
`ifdef AXONERVE_KVS_SEQ_PERF_CNT_EN
          bus.perf_cycles    <= '0;
`endif
          if (bus.ctrl_xfer_size_in_bytes == '0) begin
            bus.ap_done <= 1'b1;
            state       <= S_DONE;
          end else begin
            bus.dp_xfer_size_in_bytes <= clip(bus.ctrl_xfer_size_in_bytes);
            bus.dp_start              <= 1'b1;
            state                     <= S_ISSUE;
          end
        end
        // A done arriving in the start cycle cannot belong to this run.
        S_ISSUE: state <= S_WAIT;
        S_WAIT: if (bus.dp_done) begin
          if (!(&bus.chunk_count))
            bus.chunk_count <= bus.chunk_count + C_CNT_WIDTH'(1);
          if (rem_next == '0) begin
            bus.ap_done <= 1'b1;
            state       <= S_DONE;
          end else begin
            bus.dp_addr_offset        <= bus.dp_addr_offset + AW'(bus.dp_xfer_size_in_bytes);
            remaining                 <= rem_next;
            bus.dp_xfer_size_in_bytes <= clip(rem_next);
            bus.dp_start              <= 1'b1;
            state                     <= S_ISSUE;
          end
        end
        S_DONE: begin
          bus.ap_idle <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axonerve_kvs_job_sequencer.sv
// Job sequencer bench: vector table, hand sequences, and random jobs vs a chunk-list model.
module tb_axonerve_kvs_job_sequencer;
  localparam int AW = 64, XW = 32, CB = 65536, CW = 16;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  always #5 aclk = ~aclk;

  axonerve_kvs_job_sequencer_if #(.C_M_AXI_ADDR_WIDTH(AW), .C_XFER_SIZE_WIDTH(XW), .C_CNT_WIDTH(CW)) bus();

  axonerve_kvs_job_sequencer #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_XFER_SIZE_WIDTH(XW), .C_CHUNK_BYTES(CB), .C_CNT_WIDTH(CW)
  ) dut (.aclk(aclk), .areset(areset), .bus(bus.slave));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  typedef struct {
    logic [63:0] base;
    logic [31:0] size;
    int          dly;
    bit          busy;
    bit          early;
    int          exp_n;
    logic [31:0] exp_last;
  } vec_t;

  // Run one job; the expected chunk list comes from plain arithmetic on base/size.
  task automatic run_job(input logic [63:0] base, input logic [31:0] size, input int dly,
                         input bit busy, input bit early, output int n_got, output logic [31:0] last_sz);
    logic [63:0] ea[$];
    logic [31:0] es[$];
    logic [63:0] ga[$];
    logic [31:0] gs[$];
    int cyc, wc, last_dd, done_cyc, n_exp;
    for (longint off = 0; off < longint'(size); off += CB) begin
      ea.push_back(base + 64'(off));
      es.push_back(32'(((longint'(size) - off) < CB) ? (longint'(size) - off) : CB));
    end
    n_exp = ea.size();
    bus.ctrl_addr_offset = base;
    bus.ctrl_xfer_size_in_bytes = size;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    cyc = 0; wc = -1; last_dd = -100; done_cyc = -1;
    while (done_cyc < 0 && cyc < 4000) begin
      bus.dp_done = 1'b0;
      if (bus.dp_start) begin
        if (ga.size() == 0) chk("first_start_latency", 64'(cyc), 64'(0));
        else                chk("restart_latency", 64'(cyc), 64'(last_dd + 1));
        ga.push_back(bus.dp_addr_offset);
        gs.push_back(bus.dp_xfer_size_in_bytes);
        wc = dly;
        if (early) bus.dp_done = 1'b1;
      end
      if (bus.ap_done) begin
        done_cyc = cyc;
        chk("ap_idle_low_in_done", 64'(bus.ap_idle), 64'(0));
      end
      if (wc == 0) begin
        bus.dp_done = 1'b1;
        last_dd = cyc;
        chk("addr_stable", bus.dp_addr_offset, ga[$]);
        chk("size_stable", 64'(bus.dp_xfer_size_in_bytes), 64'(gs[$]));
      end
      if (wc >= 0) wc--;
      if (busy && wc > 1) begin
        bus.ap_start = 1'($urandom_range(0, 1));
        bus.ctrl_addr_offset = 64'hDEAD00;
      end else begin
        bus.ap_start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.dp_done = 1'b0;
    bus.ap_start = 1'b0;
    if (done_cyc < 0) chk("ap_done_timeout", 64'(0), 64'(1));
    chk("chunk_total", 64'(ga.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < ga.size(); i++) begin
      chk("chunk_addr", ga[i], ea[i]);
      chk("chunk_size", 64'(gs[i]), 64'(es[i]));
    end
    if (n_exp == 0) chk("done_latency_zero", 64'(done_cyc), 64'(0));
    else            chk("done_latency", 64'(done_cyc), 64'(last_dd + 1));
    chk("ap_idle_after_done", 64'(bus.ap_idle), 64'(1));
    chk("ap_done_one_cycle", 64'(bus.ap_done), 64'(0));
    chk("chunk_count", 64'(bus.chunk_count), 64'((n_exp > 65535) ? 65535 : n_exp));
`ifdef AXONERVE_KVS_SEQ_PERF_CNT_EN
    chk("perf_cycles", 64'(bus.perf_cycles), 64'(n_exp * (dly + 1)));
`endif
    n_got = ga.size();
    last_sz = (gs.size() > 0) ? gs[$] : 32'd0;
  endtask

  vec_t vecs[6];
  int n_got;
  logic [31:0] last_sz;
  int starts, wc, cyc;

  initial begin
    bus.ap_start = 1'b0;
    bus.dp_done = 1'b0;
    bus.ctrl_addr_offset = '0;
    bus.ctrl_xfer_size_in_bytes = '0;
    vecs[0] = '{64'h1000,                 32'd4096,   10, 1'b0, 1'b0, 1, 32'd4096};
    vecs[1] = '{64'h0,                    32'd150016,  3, 1'b0, 1'b0, 3, 32'd18944};
    vecs[2] = '{64'h0,                    32'd0,       1, 1'b0, 1'b0, 0, 32'd0};
    vecs[3] = '{64'h5000,                 32'd131072,  6, 1'b1, 1'b0, 2, 32'd65536};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_0000,  32'd196608,  2, 1'b0, 1'b0, 3, 32'd65536};
    vecs[5] = '{64'h40,                   32'd64,      1, 1'b0, 1'b1, 1, 32'd64};

    #1 areset = 1'b1;
    tick(); tick();
    chk("rst_ap_done", 64'(bus.ap_done), 64'(0));
    chk("rst_ap_idle", 64'(bus.ap_idle), 64'(1));
    chk("rst_dp_start", 64'(bus.dp_start), 64'(0));
    chk("rst_dp_addr", bus.dp_addr_offset, 64'(0));
    chk("rst_dp_size", 64'(bus.dp_xfer_size_in_bytes), 64'(0));
    chk("rst_chunk_count", 64'(bus.chunk_count), 64'(0));
    areset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_job(vecs[v].base, vecs[v].size, vecs[v].dly, vecs[v].busy, vecs[v].early, n_got, last_sz);
      chk("tbl_nchunks", 64'(n_got), 64'(vecs[v].exp_n));
      if (vecs[v].exp_n > 0) chk("tbl_last_size", 64'(last_sz), 64'(vecs[v].exp_last));
      tick();
    end

    // Stray dp_done while idle must not disturb anything.
    bus.dp_done = 1'b1;
    tick();
    bus.dp_done = 1'b0;
    tick();
    chk("idle_done_count", 64'(bus.chunk_count), 64'(1));
    chk("idle_done_no_apdone", 64'(bus.ap_done), 64'(0));
    chk("idle_done_idle", 64'(bus.ap_idle), 64'(1));

    // Reset during WAIT of chunk 2.
    bus.ctrl_addr_offset = 64'h0;
    bus.ctrl_xfer_size_in_bytes = 32'(3 * CB);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    starts = 0; wc = -1; cyc = 0;
    while (cyc < 200 && !(starts == 2 && wc == 0)) begin
      bus.dp_done = 1'b0;
      if (bus.dp_start) begin starts++; wc = 3; end
      if (starts == 1 && wc == 1) bus.dp_done = 1'b1;
      if (wc > 0) wc--;
      tick();
      cyc++;
    end
    bus.dp_done = 1'b0;
    chk("rst_mid_reached", 64'(starts), 64'(2));
    #2 areset = 1'b1;
    #1;
    chk("mid_rst_ap_idle", 64'(bus.ap_idle), 64'(1));
    chk("mid_rst_dp_addr", bus.dp_addr_offset, 64'(0));
    chk("mid_rst_dp_size", 64'(bus.dp_xfer_size_in_bytes), 64'(0));
    chk("mid_rst_chunk_count", 64'(bus.chunk_count), 64'(0));
    chk("mid_rst_dp_start", 64'(bus.dp_start), 64'(0));
    tick();
    chk("mid_rst_no_apdone", 64'(bus.ap_done), 64'(0));
    areset = 1'b0;
    tick();
    chk("post_rst_no_apdone", 64'(bus.ap_done), 64'(0));
    run_job(64'h40, 32'd64, 3, 1'b0, 1'b0, n_got, last_sz);
    chk("post_rst_job", 64'(n_got), 64'(1));
    tick();

`ifdef AXONERVE_KVS_SEQ_PERF_CNT_EN
    run_job(64'h1000, 32'd4096, 20, 1'b0, 1'b0, n_got, last_sz);
    tick(); tick(); tick();
    chk("perf_hold", 64'(bus.perf_cycles), 64'(21));
`endif

    for (int r = 0; r < 20; r++) begin
      run_job({$urandom, $urandom}, 32'(64 * $urandom_range(0, 4000)), int'($urandom_range(1, 6)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n_got, last_sz);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
